// File: rtl/seq_pattern_serializer_if.sv
// Request/response bundle for the serial pattern transmitter.
// Master loads the job and watches the serial stream; slave is the transmitter.
interface seq_pattern_serializer_if #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8,
    parameter int GAP_W   = 4
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               start;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic [CNT_W-1:0]   repeat_cnt;
    logic [GAP_W-1:0]   gap;
    logic               abort;
    logic               dout;
    logic               dvalid;
    logic               sop;
    logic               busy;
    logic               done;

    modport master (
        output start, pattern, len, repeat_cnt, gap, abort,
        input  dout, dvalid, sop, busy, done
    );

    modport slave (
        input  start, pattern, len, repeat_cnt, gap, abort,
        output dout, dvalid, sop, busy, done
    );
endinterface

// File: rtl/seq_pattern_serializer.sv
// MSB-first serial pattern transmitter with repeat count and idle gap.
// Every output is a flop loaded with the value for the coming cycle.
module seq_pattern_serializer #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8,
    parameter int GAP_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    seq_pattern_serializer_if.slave   bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t             state;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx;
    logic [CNT_W-1:0]   rem;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gcnt;

    logic               len_ok;
    logic               accept;
    logic [LEN_W-1:0]   in_top;
    logic [LEN_W-1:0]   q_top;
    logic [LEN_W-1:0]   idx_dec;
    logic               in_first;
    logic               q_first;
    logic               q_next;

    // Shift instead of a variable bit-select so idx width may exceed the index range
    function automatic logic bit_at(
        input logic [MAX_LEN-1:0] p,
        input logic [LEN_W-1:0]   i
    );
        logic [MAX_LEN-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    assign len_ok   = (bus.len != '0) && (bus.len <= LEN_W'(MAX_LEN));
    assign accept   = bus.start && len_ok &&
                      ((state == IDLE) || (state == DONE));
    assign in_top   = bus.len - LEN_W'(1);
    assign q_top    = len_q - LEN_W'(1);
    assign idx_dec  = idx - LEN_W'(1);
    assign in_first = bit_at(bus.pattern, in_top);
    assign q_first  = bit_at(pat_q, q_top);
    assign q_next   = bit_at(pat_q, idx_dec);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pat_q      <= '0;
            len_q      <= '0;
            idx        <= '0;
            rem        <= '0;
            gap_q      <= '0;
            gcnt       <= '0;
            bus.dout   <= 1'b0;
            bus.dvalid <= 1'b0;
            bus.sop    <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            bus.dout   <= 1'b0;
            bus.dvalid <= 1'b0;
            bus.sop    <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state      <= SEND;
                        pat_q      <= bus.pattern;
                        len_q      <= bus.len;
                        gap_q      <= bus.gap;
                        idx        <= in_top;
                        rem        <= (bus.repeat_cnt == '0) ?
                                      CNT_W'(1) : bus.repeat_cnt;
                        gcnt       <= '0;
                        bus.dout   <= in_first;
                        bus.dvalid <= 1'b1;
                        bus.sop    <= 1'b1;
                        bus.busy   <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND: begin
                    if (bus.abort) begin
                        state <= IDLE;
                        idx   <= '0;
                        rem   <= '0;
                        gcnt  <= '0;
                    end else if (idx != '0) begin
                        idx        <= idx_dec;
                        bus.dout   <= q_next;
                        bus.dvalid <= 1'b1;
                        bus.busy   <= 1'b1;
                    end else if (rem == CNT_W'(1)) begin
                        state    <= DONE;
                        rem      <= '0;
                        bus.done <= 1'b1;
                    end else begin
                        rem      <= rem - CNT_W'(1);
                        bus.busy <= 1'b1;
                        if (gap_q != '0) begin
                            state <= GAP;
                            gcnt  <= gap_q;
                        end else begin
                            idx        <= q_top;
                            bus.dout   <= q_first;
                            bus.dvalid <= 1'b1;
                            bus.sop    <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        state <= IDLE;
                        idx   <= '0;
                        rem   <= '0;
                        gcnt  <= '0;
                    end else if (gcnt == GAP_W'(1)) begin
                        state      <= SEND;
                        gcnt       <= '0;
                        idx        <= q_top;
                        bus.dout   <= q_first;
                        bus.dvalid <= 1'b1;
                        bus.sop    <= 1'b1;
                        bus.busy   <= 1'b1;
                    end else begin
                        gcnt     <= gcnt - GAP_W'(1);
                        bus.busy <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
